// File: rtl/seq_mult_hs.sv
// Shift-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH, with a start/busy/rdy
// handshake and run-time signed/unsigned selection. Latency is exactly WIDTH cycles.
module seq_mult_hs #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               rdy,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic             sign_p;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    result;

  // Magnitudes stay WIDTH-bit unsigned, so the most negative operand maps cleanly
  // onto 2^(WIDTH-1) instead of overflowing.
  assign mag_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // A zero magnitude product is forced positive so sign_p can never yield -0.
  assign result = (sign_p && (acc_next != '0)) ? (~acc_next + 1'b1) : acc_next;

  assign busy = (state == RUN);
  assign rdy  = (state == DONE);

  always_ff @(posedge clk) begin
    // NOTE: every register here is updated with <= so all of them see the values
    // from before the edge; blocking = would let later lines read half-updated state.
    if (reset) begin
      // NOTE: the datapath registers are reset too (not just the FSM) so the
      // outputs and the next capture never depend on power-up contents.
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sign_p <= 1'b0;
      p      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= RUN;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            sign_p <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            p     <= result;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
